// File: rtl/board_input_reader_if.sv
// Polled read port of the board input reader: one-cycle strobe in, registered data out.
interface board_input_reader_if;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (output rd_en, rd_addr, input rd_data, rd_valid);
    modport slave  (input rd_en, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/board_input_reader.sv
// Switch/button sampler with debounce, press edge flags and a memory-mapped read port.
// Optional release flags at addr 2 bits [7:4] when BTN_RELEASE_FLAG_EN is defined.

module board_input_btn_lane #(
    parameter int DB_COUNT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic level_d
);
    logic [1:0] sync;
    logic [7:0] cnt;

    // cnt tracks consecutive ticks on which the synchronised pin disagrees with level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], raw};
            level_d <= level;
            if (tick) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == 8'(DB_COUNT - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end
endmodule

module board_input_reader #(
    parameter int N_SW     = 16,
    parameter int N_BTN    = 4,
    parameter int DB_TICK  = 1000,
    parameter int DB_COUNT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_SW-1:0]      sw_in,
    input  logic [N_BTN-1:0]     btn_in,
    board_input_reader_if.slave  rd,
    output logic                 press_any
);
    localparam int PW = (DB_TICK > 1) ? $clog2(DB_TICK) : 1;

    logic [PW-1:0]    pre;
    logic             tick;
    logic [N_SW-1:0]  sw_s1, sw_q;
    logic [N_BTN-1:0] lvl, lvl_d, press;
    logic [3:0]       press4, pflag;
    logic [7:0]       flag_all, press_cnt0;
    logic             clr;
    logic [31:0]      rd_word;

    assign tick = (pre == PW'(DB_TICK - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + PW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_s1 <= '0;
            sw_q  <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_q  <= sw_s1;
        end
    end

    board_input_btn_lane #(.DB_COUNT(DB_COUNT)) u_lane [N_BTN-1:0] (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn_in),
        .tick    (tick),
        .level   (lvl),
        .level_d (lvl_d)
    );

    assign press = lvl & ~lvl_d;
    assign clr   = rd.rd_en && (rd.rd_addr == 2'd2);

    always_comb begin
        press4               = '0;
        press4[N_BTN-1:0]    = press;
    end

    // Set has priority over the read-clear so a press landing on the clear is kept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pflag <= '0;
        else      pflag <= (clr ? 4'b0 : pflag) | press4;
    end

`ifdef BTN_RELEASE_FLAG_EN
    logic [3:0] rel4, rflag;

    always_comb begin
        rel4                 = '0;
        rel4[N_BTN-1:0]      = ~lvl & lvl_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rflag <= '0;
        else      rflag <= (clr ? 4'b0 : rflag) | rel4;
    end

    assign flag_all = {rflag, pflag};
`else
    assign flag_all = {4'b0, pflag};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_any  <= 1'b0;
            press_cnt0 <= '0;
        end else begin
            press_any <= |flag_all;
            if (press[0]) press_cnt0 <= press_cnt0 + 8'd1;
        end
    end

    always_comb begin
        rd_word = '0;
        case (rd.rd_addr)
            2'd0:    rd_word[N_SW-1:0]  = sw_q;
            2'd1:    rd_word[N_BTN-1:0] = lvl;
            2'd2:    rd_word[7:0]       = flag_all;
            default: rd_word[7:0]       = press_cnt0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd.rd_valid <= 1'b0;
            rd.rd_data  <= '0;
        end else begin
            rd.rd_valid <= rd.rd_en;
            if (rd.rd_en) rd.rd_data <= rd_word;
        end
    end
endmodule

// File: tb/tb_board_input_reader.sv
// Randomised bench for board_input_reader against an event-level model of settled button state.
module tb_board_input_reader;
    localparam int N_SW = 16, N_BTN = 4, SETTLE = 24;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_SW-1:0]  sw_in = '0;
    logic [N_BTN-1:0] btn_in = '0;
    logic             press_any;

    board_input_reader_if rif();

    board_input_reader #(.N_SW(N_SW), .N_BTN(N_BTN), .DB_TICK(4), .DB_COUNT(3)) dut (
        .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in), .rd(rif), .press_any(press_any)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    // model: settled levels, sticky flags, button-0 press count
    logic [N_BTN-1:0] m_lvl;
    logic [7:0]       m_flags;
    logic [7:0]       m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_lvl = '0; m_flags = '0; m_cnt = '0;
    endtask

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {16'b0, sw_in};
            2'd1:    return {28'b0, m_lvl};
            2'd2:    return {24'b0, m_flags};
            default: return {24'b0, m_cnt};
        endcase
    endfunction

    // Move button b to level v (optionally with a short burst of noise first) and let it settle
    task automatic btn_set(input int b, input logic v, input bit noisy);
        if (noisy) repeat ($urandom_range(0, 7)) begin
            @(negedge clk); btn_in[b] = 1'($urandom);
        end
        @(negedge clk); btn_in[b] = v;
        repeat (SETTLE) @(negedge clk);
        if (v && !m_lvl[b]) begin
            m_flags[b] = 1'b1;
            if (b == 0) m_cnt = m_cnt + 8'd1;
        end
`ifdef BTN_RELEASE_FLAG_EN
        if (!v && m_lvl[b]) m_flags[b+4] = 1'b1;
`endif
        m_lvl[b] = v;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk); rif.rd_en = 1'b1; rif.rd_addr = a;
        @(negedge clk); rif.rd_en = 1'b0;
        chk($sformatf("valid_a%0d", a), {31'b0, rif.rd_valid}, 32'd1);
        chk($sformatf("data_a%0d", a), rif.rd_data, exp);
        if (a == 2'd2) begin
            chk("pany_before_clr", {31'b0, press_any}, {31'b0, |exp[7:0]});
            m_flags = '0;
        end else begin
            chk("pany", {31'b0, press_any}, {31'b0, |m_flags});
        end
        @(negedge clk);
        chk("valid_drop", {31'b0, rif.rd_valid}, 32'd0);
        chk("data_hold", rif.rd_data, exp);
        chk("pany_after", {31'b0, press_any}, {31'b0, |m_flags});
    endtask

    task automatic rdm(input logic [1:0] a);
        rd(a, model_reg(a));
    endtask

    initial begin
        int hits, bad;
        rif.rd_en = 1'b0; rif.rd_addr = '0;
        model_reset();

        // reset state
        sw_in = 16'hA5A5;
        repeat (4) @(negedge clk);
        chk("rst_data", rif.rd_data, 32'd0);
        chk("rst_valid", {31'b0, rif.rd_valid}, 32'd0);
        chk("rst_pany", {31'b0, press_any}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rd(2'd0, 32'h0000A5A5);
        rd(2'd1, 32'h0);
        rd(2'd3, 32'h0);

        // bounce with period 8 never yields three consecutive agreeing ticks
        for (int i = 0; i < 5; i++) begin
            btn_in[0] = 1'b1; repeat (4) @(negedge clk);
            btn_in[0] = 1'b0; repeat (4) @(negedge clk);
        end
        rd(2'd1, 32'h0);
        btn_set(0, 1'b1, 1'b0);
        rd(2'd1, 32'h1);
        rd(2'd3, 32'h1);
        btn_set(0, 1'b0, 1'b0);
        rdm(2'd2);

        // btn2 press, read-clear
        btn_set(2, 1'b1, 1'b0);
        rd(2'd2, 32'h4);
        rd(2'd2, 32'h0);
        btn_set(2, 1'b0, 1'b0);
        rdm(2'd2);

        // btn1 press under continuous addr-2 reads: exactly one read must see it
        hits = 0; bad = 0;
        btn_in[1] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (rif.rd_data == 32'h2) hits++;
                else if (rif.rd_data != 32'h0) bad++;
            end
            rif.rd_en = 1'b1; rif.rd_addr = 2'd2;
        end
        @(negedge clk); rif.rd_en = 1'b0;
        if (rif.rd_data == 32'h2) hits++;
        else if (rif.rd_data != 32'h0) bad++;
        chk("setwin_hits", hits, 32'd1);
        chk("setwin_other", bad, 32'd0);
        m_lvl[1] = 1'b1;
        repeat (2) @(negedge clk);
        rdm(2'd2);
        rdm(2'd1);

        // press and release btn3
        btn_set(3, 1'b1, 1'b0);
        btn_set(3, 1'b0, 1'b0);
`ifdef BTN_RELEASE_FLAG_EN
        rd(2'd2, 32'h88);
`else
        rd(2'd2, 32'h08);
`endif
        btn_set(1, 1'b0, 1'b0);
        rdm(2'd2);

        // reset mid-read drops rd_valid at once
        @(negedge clk); rif.rd_en = 1'b1; rif.rd_addr = 2'd0;
        @(posedge clk); #1;
        chk("midrd_valid_pre", {31'b0, rif.rd_valid}, 32'd1);
        rst = 1'b0; #1;
        chk("midrd_valid", {31'b0, rif.rd_valid}, 32'd0);
        chk("midrd_data", rif.rd_data, 32'd0);
        rif.rd_en = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b1;

        // reset mid-debounce discards partial count
        btn_in[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0; btn_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        rd(2'd1, 32'h0);
        rd(2'd3, 32'h0);

        // 256 presses wrap the counter
        for (int i = 0; i < 256; i++) begin
            btn_set(0, 1'b1, 1'b0);
            btn_set(0, 1'b0, 1'b0);
        end
        rd(2'd3, 32'h0);
        rdm(2'd2);

        // random toggles with noise, random switch values, random reads
        for (int i = 0; i < 40; i++) begin
            int b;
            sw_in = 16'($urandom);
            b = $urandom_range(0, N_BTN - 1);
            btn_set(b, ~m_lvl[b], 1'b1);
            repeat ($urandom_range(1, 3)) rdm(2'($urandom_range(0, 3)));
        end
        rdm(2'd0);
        rdm(2'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
